// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline hazard/sequencing controller:
// FSM encodings, forwarding-select encodings and parameter defaults.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      StRun   = 2'b00,
      StDrain = 2'b01,
      StFire  = 2'b10,
      StHalt  = 2'b11
   } ctrl_state_e;

   localparam logic [1:0] FwdReg = 2'b00;
   localparam logic [1:0] FwdWb  = 2'b01;
   localparam logic [1:0] FwdMem = 2'b10;

   localparam int unsigned DefDrainCycles = 3;
   localparam int unsigned DefExitCode    = 10;

   // A destination matches a source only when it is a real register ($0 never matches).
   function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
      return (dst != 5'd0) && (dst == src);
   endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller: stage register
// indices and control bits in, stall/flush/forward/syscall controls out.
interface pipeline_ctrl_if;

   logic [4:0]  Rs_D;
   logic [4:0]  Rt_D;
   logic        branch_D;
   logic        jr_D;
   logic        syscall_D;
   logic        pcsrc_D;
   logic [31:0] v0_D;
   logic [4:0]  Rs_E;
   logic [4:0]  Rt_E;
   logic [4:0]  writeReg_E;
   logic        regWrite_E;
   logic        memToReg_E;
   logic [4:0]  writeReg_M;
   logic        regWrite_M;
   logic        memToReg_M;
   logic [4:0]  writeReg_W;
   logic        regWrite_W;

   logic        stall_F;
   logic        stall_D;
   logic        flush_D;
   logic        flush_E;
   logic [1:0]  fwdA_E;
   logic [1:0]  fwdB_E;
   logic        fwdA_D;
   logic        fwdB_D;
   logic        syscall_fire;
   logic        halt;
   logic [31:0] stall_count;

   modport master (
      output Rs_D, Rt_D, branch_D, jr_D, syscall_D, pcsrc_D, v0_D,
      output Rs_E, Rt_E, writeReg_E, regWrite_E, memToReg_E,
      output writeReg_M, regWrite_M, memToReg_M, writeReg_W, regWrite_W,
      input  stall_F, stall_D, flush_D, flush_E, fwdA_E, fwdB_E, fwdA_D, fwdB_D,
      input  syscall_fire, halt, stall_count
   );

   modport slave (
      input  Rs_D, Rt_D, branch_D, jr_D, syscall_D, pcsrc_D, v0_D,
      input  Rs_E, Rt_E, writeReg_E, regWrite_E, memToReg_E,
      input  writeReg_M, regWrite_M, memToReg_M, writeReg_W, regWrite_W,
      output stall_F, stall_D, flush_D, flush_E, fwdA_E, fwdB_E, fwdA_D, fwdB_D,
      output syscall_fire, halt, stall_count
   );

endinterface

// File: rtl/pipeline_ctrl_forward_unit.sv
// Combinational operand forwarding for the EX-stage ALU muxes and the
// ID-stage branch comparator. MEM takes priority over WB as the younger result.
module pipeline_ctrl_forward_unit
   import pipeline_ctrl_pkg::*;
(
   input  logic [4:0] rs_e_i,
   input  logic [4:0] rt_e_i,
   input  logic [4:0] rs_d_i,
   input  logic [4:0] rt_d_i,
   input  logic [4:0] write_reg_m_i,
   input  logic       reg_write_m_i,
   input  logic [4:0] write_reg_w_i,
   input  logic       reg_write_w_i,
   output logic [1:0] fwd_a_e_o,
   output logic [1:0] fwd_b_e_o,
   output logic       fwd_a_d_o,
   output logic       fwd_b_d_o
);

   always_comb begin
      fwd_a_e_o = FwdReg;
      if (reg_write_m_i && reg_match(write_reg_m_i, rs_e_i)) begin
         fwd_a_e_o = FwdMem;
      end else if (reg_write_w_i && reg_match(write_reg_w_i, rs_e_i)) begin
         fwd_a_e_o = FwdWb;
      end
   end

   always_comb begin
      fwd_b_e_o = FwdReg;
      if (reg_write_m_i && reg_match(write_reg_m_i, rt_e_i)) begin
         fwd_b_e_o = FwdMem;
      end else if (reg_write_w_i && reg_match(write_reg_w_i, rt_e_i)) begin
         fwd_b_e_o = FwdWb;
      end
   end

   assign fwd_a_d_o = reg_write_m_i && reg_match(write_reg_m_i, rs_d_i);
   assign fwd_b_d_o = reg_write_m_i && reg_match(write_reg_m_i, rt_d_i);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the five-stage MIPS pipeline: load/branch
// stalls, forwarding, syscall drain/fire/halt FSM and a saturating stall counter.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = DefDrainCycles,
   parameter int unsigned EXIT_CODE    = DefExitCode
) (
   input logic            clk,
   input logic            reset,
   pipeline_ctrl_if.slave bus
);

   localparam int unsigned CntW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

   ctrl_state_e     state_q, state_d;
   logic [CntW-1:0] drain_q, drain_d;
   logic [31:0]     stall_count_q, stall_count_d;

   logic [1:0] fwd_a_e, fwd_b_e;
   logic       fwd_a_d, fwd_b_d;
   logic       hit_e, hit_m, lwstall, brstall, hazard;
   logic       stall, flush_d, fire, halt;

   pipeline_ctrl_forward_unit u_forward_unit (
      .rs_e_i        (bus.Rs_E),
      .rt_e_i        (bus.Rt_E),
      .rs_d_i        (bus.Rs_D),
      .rt_d_i        (bus.Rt_D),
      .write_reg_m_i (bus.writeReg_M),
      .reg_write_m_i (bus.regWrite_M),
      .write_reg_w_i (bus.writeReg_W),
      .reg_write_w_i (bus.regWrite_W),
      .fwd_a_e_o     (fwd_a_e),
      .fwd_b_e_o     (fwd_b_e),
      .fwd_a_d_o     (fwd_a_d),
      .fwd_b_d_o     (fwd_b_d)
   );

   assign hit_e = reg_match(bus.writeReg_E, bus.Rs_D) || reg_match(bus.writeReg_E, bus.Rt_D);
   assign hit_m = reg_match(bus.writeReg_M, bus.Rs_D) || reg_match(bus.writeReg_M, bus.Rt_D);

   assign lwstall = bus.memToReg_E && bus.regWrite_E && hit_e;
   // Branch compares in ID, so it must also wait on an ALU result still in EX
   // and on a load result still in MEM.
   assign brstall = (bus.branch_D || bus.jr_D) &&
                    ((bus.regWrite_E && hit_e) || (bus.memToReg_M && hit_m));
   assign hazard  = lwstall || brstall;

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      stall   = 1'b0;
      flush_d = 1'b0;
      fire    = 1'b0;
      halt    = 1'b0;
      case (state_q)
         StRun: begin
            stall = hazard;
            if (bus.syscall_D && !hazard) begin
               stall   = 1'b1;
               drain_d = CntW'(DRAIN_CYCLES - 1);
               state_d = (DRAIN_CYCLES > 1) ? StDrain : StFire;
            end
            flush_d = bus.pcsrc_D && !stall;
         end
         StDrain: begin
            stall   = 1'b1;
            drain_d = drain_q - CntW'(1);
            if (drain_q <= CntW'(1)) begin
               state_d = StFire;
            end
         end
         StFire: begin
            fire    = 1'b1;
            state_d = (bus.v0_D == EXIT_CODE) ? StHalt : StRun;
         end
         StHalt: begin
            stall = 1'b1;
            halt  = 1'b1;
         end
         default: state_d = StRun;
      endcase
   end

   // HALT stalls are excluded so the statistic reflects only real run time.
   always_comb begin
      stall_count_d = stall_count_q;
      if (stall && (state_q == StRun || state_q == StDrain) && (stall_count_q != 32'hFFFF_FFFF)) begin
         stall_count_d = stall_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StRun;
         drain_q       <= '0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         drain_q       <= drain_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign bus.stall_F      = !reset && stall;
   assign bus.stall_D      = !reset && stall;
   assign bus.flush_E      = !reset && stall;
   assign bus.flush_D      = !reset && flush_d;
   assign bus.syscall_fire = !reset && fire;
   assign bus.halt         = !reset && halt;
   assign bus.fwdA_E       = reset ? FwdReg : fwd_a_e;
   assign bus.fwdB_E       = reset ? FwdReg : fwd_b_e;
   assign bus.fwdA_D       = !reset && fwd_a_d;
   assign bus.fwdB_D       = !reset && fwd_b_d;
   assign bus.stall_count  = reset ? 32'd0 : stall_count_q;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the five-stage MIPS pipeline.
- Watches register indices and control bits in the ID, EX, MEM and WB stages.
- Drives stall/flush enables for the IF_ID and ID_EX pipeline registers, and forwarding selects for the EX-stage ALU operand muxes and the ID-stage branch comparator.
- Owns a small FSM that drains the pipeline before a syscall executes and latches a halt on the exit syscall.
- Keeps a saturating stall-cycle count for the end-of-run statistics.

## Interface
Parameters:
- DRAIN_CYCLES, 3, cycles waited after a syscall reaches ID before it fires
- EXIT_CODE, 10, v0 value that makes a syscall halt the machine

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- Rs_D, Rt_D  in  5  source register indices of the instruction in ID
- branch_D, jr_D, syscall_D, pcsrc_D  in  1  ID branch, jr and syscall decode; pcsrc_D = branch or jump taken
- v0_D  in  32  current v0 register value
- Rs_E, Rt_E, writeReg_E  in  5  EX-stage source and destination indices
- regWrite_E, memToReg_E  in  1  EX-stage WB control bits
- writeReg_M  in  5  MEM-stage destination index
- regWrite_M, memToReg_M  in  1  MEM-stage WB control bits
- writeReg_W  in  5  WB-stage destination index
- regWrite_W  in  1  WB-stage register-write enable
- stall_F, stall_D  out  1  hold PC / hold IF_ID
- flush_D, flush_E  out  1  clear IF_ID / clear ID_EX (insert bubble)
- fwdA_E, fwdB_E  out  2  EX operand select: 00 = register file, 01 = Result_W, 10 = ALUOut_M
- fwdA_D, fwdB_D  out  1  ID comparator operand: 1 = ALUOut_M
- syscall_fire  out  1  one-cycle strobe to the Syscall block
- halt  out  1  sticky; gates the clock generator and statistics
- stall_count  out  32  cycles with stall_F high, excluding HALT

## Operation
Match rules:
- A destination "matches" a source when the indices are equal and the destination is nonzero.
- $0 is never forwarded and never causes a stall.

Forwarding (combinational, in every state):
- fwdA_E = 10 if regWrite_M and writeReg_M matches Rs_E.
- Otherwise fwdA_E = 01 if regWrite_W and writeReg_W matches Rs_E.
- Otherwise fwdA_E = 00.
- fwdB_E follows the same rules against Rt_E.
- fwdA_D = regWrite_M and writeReg_M matches Rs_D. fwdB_D uses Rt_D.

Hazard terms:
- lwstall = memToReg_E and regWrite_E and writeReg_E matches Rs_D or Rt_D.
- brstall = (branch_D or jr_D) and either:
  - regWrite_E and writeReg_E matches Rs_D or Rt_D, or
  - memToReg_M and writeReg_M matches Rs_D or Rt_D.

FSM states are RUN, DRAIN, FIRE and HALT.
- RUN:
  - stall_F = stall_D = flush_E = lwstall or brstall.
  - flush_D = pcsrc_D and not stall_D.
  - If syscall_D is high and neither stall term is high: assert stall_F, stall_D and flush_E; load drain counter with DRAIN_CYCLES−1; go to DRAIN.
- DRAIN:
  - stall_F, stall_D and flush_E are held at 1.
  - The counter decrements each cycle; when it reaches 0, go to FIRE.
- FIRE:
  - syscall_fire = 1; stalls are released so the syscall advances to EX.
  - If v0_D == EXIT_CODE, go to HALT, else go to RUN.
- HALT:
  - stall_F, stall_D, flush_E and halt are all 1; syscall_fire = 0.
  - Only reset leaves HALT.
- Priority: reset > HALT > DRAIN/FIRE > hazard stalls > flush_D.
- stall_count increments on each cycle with stall_F = 1 in RUN or DRAIN. It saturates at 0xFFFFFFFF.

## Timing
- Forwarding and stall/flush outputs are combinational from inputs and state. They are valid within the same cycle.
- A load-use stall lasts 1 cycle; a branch-after-load stall lasts 2 cycles.
- Syscall latency: detection cycle, then DRAIN_CYCLES−1 DRAIN cycles, then FIRE. syscall_fire rises 3 cycles after syscall_D first rises with the default parameter.
- At FIRE, every older instruction has completed WB.
- Back-to-back syscalls: syscall_D high in the cycle after FIRE starts a fresh drain.
- While reset is high:
  - state = RUN and stall_count = 0.
  - All 1-bit outputs are 0, and fwd* = 00.
- Reset asserted mid-DRAIN or in HALT returns to RUN on the next edge, with no syscall_fire.

## Structure
- The shared header (mips.h) holds:
  - FSM state encodings (2-bit)
  - FWD_REG / FWD_WB / FWD_MEM encodings
  - the default EXIT_CODE and DRAIN_CYCLES values
- Sub-module forward_unit: purely combinational EX and ID forwarding, instantiated once.
- The FSM, hazard terms and counter live in pipeline_ctrl.

## Test plan
- Dependent ALU chain (`add $t0..; sub $t1,$t0..`) → fwdA_E = 10 in the consumer's EX cycle. With one instruction between them → 01. No stalls.
- `lw $t0,0($s0); add $t1,$t0,$t2` → exactly 1 cycle of stall_F = stall_D = flush_E = 1, then fwdA_E = 01. stall_count = 1.
- `lw $t0`, then `beq $t0,$t1` → 2 stall cycles, then fwdA_D = 0 and a correct taken branch with flush_D = 1 for 1 cycle.
- Writes to $0 followed by reads of $0 → fwd* = 00 and no stalls.
- v0 = 1 set just before a syscall → 3-cycle drain, then syscall_fire for 1 cycle with v0_D = 1, then back to RUN. v0 = 10 → HALT with halt = 1 held for 20+ cycles.
- Reset pulse in DRAIN, and separately in HALT → next cycle is RUN, all outputs 0, stall_count = 0.
